// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and 16x oversampling tick constants.
// The transmitter reuses this package.
package uart_pkg;

  localparam int OVS_TICKS = 16;
  localparam int MID_TICK  = 7;
  localparam int LAST_TICK = 15;
  localparam int TICK_W    = $clog2(OVS_TICKS);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_state_e;

  function automatic logic tick_is(input logic [TICK_W-1:0] tcnt, input int target);
    return tcnt == TICK_W'(target);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: line input, tick enable, and received-byte outputs.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 ce_16;
  logic                 ser_in;
  logic [DATA_BITS-1:0] rx_data;
  logic                 new_rx_data;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (
    output ce_16, ser_in,
    input  rx_data, new_rx_data, frame_err, parity_err, busy
  );

  modport slave (
    input  ce_16, ser_in,
    output rx_data, new_rx_data, frame_err, parity_err, busy
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with selectable reset level.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/uart_rx.sv
// 8N1 (optionally 8E1/8O1) receiver driven by a 16x baud tick enable.
// Define UART_RX_PARITY_EN to build in the parity bit and parity check.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  uart_rx_if.slave   bus
);
  localparam int                BCNT_W   = 3;
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_BITS - 1);

  logic rx_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d_i     (bus.ser_in),
    .q_o     (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [TICK_W-1:0]    tcnt_q, tcnt_d;
  logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 new_q, new_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
`else
  logic                 unused_parity_cfg;
  assign unused_parity_cfg = PARITY_ODD;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      new_q     <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      new_q     <= new_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    bcnt_d    = bcnt_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    new_d     = 1'b0;
    ferr_d    = ferr_q;
    perr_d    = perr_q;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
`endif
    if (bus.ce_16) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d = ST_START;
            tcnt_d  = '0;
          end
        end
        ST_START: begin
          tcnt_d = tcnt_q + 1'b1;
          // Mid-bit recheck rejects glitches shorter than half a bit
          if (tick_is(tcnt_q, MID_TICK)) begin
            if (!rx_s) begin
              state_d = ST_DATA;
              tcnt_d  = '0;
              bcnt_d  = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          tcnt_d = tcnt_q + 1'b1;
          if (tick_is(tcnt_q, LAST_TICK)) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            bcnt_d  = bcnt_q + 1'b1;
            if (bcnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          tcnt_d = tcnt_q + 1'b1;
          if (tick_is(tcnt_q, LAST_TICK)) begin
            par_d   = rx_s;
            state_d = ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          tcnt_d = tcnt_q + 1'b1;
          if (tick_is(tcnt_q, LAST_TICK)) begin
            rx_data_d = shift_q;
            ferr_d    = ~rx_s;
`ifdef UART_RX_PARITY_EN
            perr_d    = ((^shift_q) ^ PARITY_ODD) != par_q;
`else
            perr_d    = 1'b0;
`endif
            new_d     = 1'b1;
            state_d   = rx_s ? ST_IDLE : ST_WAIT_HIGH;
          end
        end
        ST_WAIT_HIGH: begin
          // Line held low past the stop bit (break): wait for idle level
          if (rx_s) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.new_rx_data = new_q;
  assign bus.frame_err   = ferr_q;
  assign bus.parity_err  = perr_q;
  assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx; define UART_RX_PARITY_EN to exercise parity builds.
module tb_uart_rx;
  localparam int DATA_BITS  = 8;
  localparam bit PARITY_ODD = 1'b0;
  localparam int DIV        = 4;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       pe;
    int         tick;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   div_cnt = 0;
  int   tick_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  int   strobes = 0;
  int   pushed = 0;
  exp_t exp_q[$];
  exp_t e;

  uart_rx_if #(.DATA_BITS(DATA_BITS)) bus();

  uart_rx #(.DATA_BITS(DATA_BITS), .PARITY_ODD(PARITY_ODD)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #10 clock = ~clock;

  initial begin
    bus.ce_16 = 1'b0;
    forever begin
      @(negedge clock);
      div_cnt   = (div_cnt == DIV - 1) ? 0 : div_cnt + 1;
      bus.ce_16 = (div_cnt == 0);
    end
  end

  always @(posedge clock) if (bus.ce_16) tick_cnt <= tick_cnt + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: frame contents follow directly from the bits put on the line;
  // stop is sampled half a bit plus (data+parity+1) bit times after the first tick seeing low.
  function automatic exp_t model(input logic [7:0] d, input logic par, input logic stop, input int s);
    exp_t m;
    m.data = d;
    m.fe   = ~stop;
`ifdef UART_RX_PARITY_EN
    m.pe   = ((^d) ^ PARITY_ODD) != par;
`else
    m.pe   = 1'b0;
`endif
    m.tick = (s + 1) + 8 + 16 * (DATA_BITS + 1 + P);
    return m;
  endfunction

  always @(negedge clock) begin
    if (reset_n && bus.new_rx_data) begin
      strobes++;
      check("strobe_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rx_data", bus.rx_data, e.data);
        check("frame_err", bus.frame_err, e.fe);
        check("parity_err", bus.parity_err, e.pe);
        check("strobe_tick", tick_cnt, e.tick);
        $display("frame data=0x%02h fe=%0b pe=%0b tick=%0d", bus.rx_data, bus.frame_err,
                 bus.parity_err, tick_cnt);
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clock);
      while (!bus.ce_16) @(posedge clock);
    end
  endtask

  task automatic drive(input logic b, input int n);
    #1 bus.ser_in = b;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int extra_low, input int abort_bit);
    int s;
    #1;
    s = tick_cnt;
    bus.ser_in = 1'b0;
    if (abort_bit < 0) begin
      exp_q.push_back(model(d, par, stop, s));
      pushed++;
    end
    wait_ticks(16);
    for (int i = 0; i < DATA_BITS; i++) begin
      if (i == abort_bit) begin
        wait_ticks(8);
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_new_rx_data", bus.new_rx_data, 0);
        check("rst_frame_err", bus.frame_err, 0);
        check("rst_parity_err", bus.parity_err, 0);
        check("rst_busy", bus.busy, 0);
        bus.ser_in = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        wait_ticks(20);
        check("post_abort_busy", bus.busy, 0);
        return;
      end
      drive(d[i], 16);
    end
`ifdef UART_RX_PARITY_EN
    drive(par, 16);
`endif
    drive(stop, 16);
    if (!stop) begin
      #1 check("busy_wait_high", bus.busy, 1);
      if (extra_low > 0) drive(1'b0, 16 * extra_low);
      drive(1'b1, 2);
      #1 check("busy_after_break", bus.busy, 0);
    end
  endtask

  initial begin
    logic [7:0] rd;
    int         st;
    int         budget;
    bus.ser_in = 1'b1;
    reset_n    = 1'b0;
    repeat (5) @(negedge clock);
    check("reset_rx_data", bus.rx_data, 0);
    check("reset_new_rx_data", bus.new_rx_data, 0);
    check("reset_frame_err", bus.frame_err, 0);
    check("reset_parity_err", bus.parity_err, 0);
    check("reset_busy", bus.busy, 0);
    reset_n = 1'b1;
    wait_ticks(4);

    send_frame(8'h55, 1'b0, 1'b1, 0, -1);
    drive(1'b1, 4);
    #1 check("busy_after_0x55", bus.busy, 0);
    check("strobes_after_0x55", strobes, 1);

    rd = bus.rx_data;
    st = strobes;
    #1 bus.ser_in = 1'b0;
    wait_ticks(4);
    #1 check("glitch_busy_in_start", bus.busy, 1);
    bus.ser_in = 1'b1;
    wait_ticks(6);
    #1 check("glitch_busy_idle", bus.busy, 0);
    check("glitch_rx_data_held", bus.rx_data, rd);
    check("glitch_no_strobe", strobes, st);

    send_frame(8'hA3, 1'b0, 1'b0, 2, -1);
    send_frame(8'h3C, 1'b0, 1'b1, 0, -1);
    drive(1'b1, 4);

    send_frame(8'h00, 1'b0, 1'b1, 0, -1);
    send_frame(8'hFF, 1'b0, 1'b1, 0, -1);
    send_frame(8'h81, 1'b0, 1'b1, 0, -1);
    drive(1'b1, 4);
    check("strobes_after_b2b", strobes, 6);

    st = strobes;
    send_frame(8'h5A, 1'b0, 1'b1, 0, 4);
    check("abort_no_strobe", strobes, st);
    send_frame(8'hC3, 1'b0, 1'b1, 0, -1);
    drive(1'b1, 4);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 0, -1);
    send_frame(8'h07, 1'b0, 1'b1, 0, -1);
    drive(1'b1, 4);
`endif

    for (int n = 0; n < 25; n++) begin
      logic [7:0] d;
      logic       par;
      logic       stop;
      int         gap;
      d    = 8'($urandom);
      par  = 1'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      gap  = $urandom_range(0, 6);
      send_frame(d, par, stop, $urandom_range(0, 2), -1);
      if (gap > 0) drive(1'b1, gap);
    end
    drive(1'b1, 4);

    budget = 0;
    while (exp_q.size() > 0 && budget < 2000) begin
      @(negedge clock);
      budget++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    check("strobe_total", strobes, pushed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that consumes the 16x-oversampling clock enable produced by the baud generator and recovers 8N1 frames from an asynchronous line. It sits between the external `ser_in` pin and the control-register logic:
- synchronises the line;
- validates the start bit at mid-bit;
- samples data LSB-first at bit centres;
- checks the stop bit;
- presents each byte with a one-cycle strobe.

## Interface
- `DATA_BITS`, 8, payload bits per frame (5..8)
- `PARITY_ODD`, 0, parity sense when parity is compiled in (0 = even, 1 = odd); ignored otherwise
- `clock`  in  1  system clock; all flops rising-edge
- `reset_n`  in  1  asynchronous, active-low reset
- `ce_16`  in  1  one-`clock` enable pulse at 16 x baud rate
- `ser_in`  in  1  asynchronous serial line; idle high
- `rx_data`  out  DATA_BITS  last received payload, held until the next frame completes
- `new_rx_data`  out  1  one-`clock` strobe: `rx_data`/`frame_err`/`parity_err` updated
- `frame_err`  out  1  last frame's stop bit sampled low
- `parity_err`  out  1  last frame's parity mismatch (constant 0 without parity)
- `busy`  out  1  high in any state other than IDLE

## Operation
- `ser_in` passes through a 2-flop synchroniser (reset value 1) → `rx_s`. Every decision uses `rx_s`.
- 4-bit tick counter `tcnt` advances only on `ce_16`. Bit counter `bcnt` counts 0..DATA_BITS-1.
- States and transitions:
  - **IDLE**: on `ce_16` with `rx_s`=0 → START, `tcnt`=0.
  - **START**:
    - `tcnt` increments per `ce_16`.
    - At `ce_16` with `tcnt`==7: if `rx_s`=0 → DATA with `tcnt`=0 and `bcnt`=0.
    - Otherwise it is a false start → IDLE with no outputs changed.
  - **DATA**:
    - At `ce_16` with `tcnt`==15, shift `rx_s` into the MSB of the shift register (LSB-first reception), then increment `bcnt`.
    - After bit DATA_BITS-1 → PARITY if compiled in, else → STOP.
    - `tcnt` wraps 15→0.
  - **PARITY**: at `tcnt`==15, sample the parity bit → STOP.
  - **STOP**: at `tcnt`==15, sample the stop bit, then:
    - load `rx_data` from the shift register;
    - set `frame_err` = ~`rx_s`;
    - set `parity_err` per check;
    - pulse `new_rx_data`.
    - If `rx_s`=1 → IDLE, else → WAIT_HIGH.
  - **WAIT_HIGH** (break/framing recovery): stay until `ce_16` with `rx_s`=1 → IDLE.
- A frame with errors is still delivered: `new_rx_data` pulses and the error flags qualify the data.
- `ce_16` low: the FSM and counters hold.
- Reset mid-frame:
  - all state returns to IDLE;
  - the partial frame is discarded;
  - no strobe.
- Reset values:
  - `rx_data`=0, `new_rx_data`=0, `frame_err`=0, `parity_err`=0, `busy`=0;
  - synchroniser=1, counters=0.

## Timing
- Input latency: 2 `clock` from `ser_in` to `rx_s`.
- Start detection is the first `ce_16` that sees `rx_s`=0 (tick T0).
- Start check at T0+8 ticks.
- Data bit k is sampled at T0+8+16(k+1) ticks.
- Stop bit is sampled at T0+8+16(DATA_BITS+1+P) ticks, where P=1 with parity, else 0.
- `new_rx_data` is high for exactly the one `clock` following the stop-sample `ce_16` edge. It is registered, with no combinational path from inputs.
- `rx_data` and the flags change only in that same cycle.
- Back-to-back frames:
  - from STOP with `rx_s`=1, the FSM is in IDLE from the next cycle;
  - the next start edge is accepted on the following `ce_16`.
- Tolerated baud mismatch: ±3 % (sampling within ±7 ticks of centre over 10 bits).

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is present and frames are start+DATA_BITS+parity+stop;
  - `parity_err` = (XOR of data bits ^ `PARITY_ODD`) != sampled bit.
- Undefined:
  - the PARITY state is not synthesised;
  - DATA goes directly to STOP;
  - `parity_err` is tied 0.

## Structure
- Shared package `uart_pkg`:
  - state encoding (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - `OVS_TICKS`=16;
  - `MID_TICK`=7;
  - `LAST_TICK`=15.
  - The transmitter reuses it.
- One sub-module: `sync_2ff` (parameterised reset value). Everything else is in `uart_rx`.

## Test plan
- 50 MHz clock, `baud_gen` at 9600, send 0x55 in 8N1 → exactly one `new_rx_data` pulse; `rx_data`=0x55; `frame_err`=0; `busy` low afterwards.
- Low glitch of 4 `ce_16` ticks on an idle line → no strobe; `rx_data` unchanged; FSM back in IDLE after 8 ticks.
- Send 0xA3 with stop bit forced 0, line held low 3 bit times → strobe with `rx_data`=0xA3 and `frame_err`=1; no new start accepted until the line goes high; the next 0x3C is received clean with `frame_err`=0.
- Back-to-back 0x00, 0xFF, 0x81 with no idle gap → three strobes with correct values; no missed frames.
- Assert `reset_n` low during data bit 4 of 0x5A → all outputs at reset values; no strobe; the following frame 0xC3 is received correctly.
- `UART_RX_PARITY_EN`, `PARITY_ODD`=0: send 0x07 with parity bit 1 → `parity_err`=0; resend 0x07 with parity bit 0 → `parity_err`=1 and `rx_data`=0x07.
